// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding, the
// address/data widths of the byte-level master, and the timer width helper.
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUSY   = 2'd2,
        FINISH = 2'd3
    } arb_state_t;

    // The timer must be able to hold the larger of the two timeout limits.
    function automatic int timer_width(input int accept_to, input int xfer_to);
        return $clog2(((accept_to > xfer_to) ? accept_to : xfer_to) + 1);
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Command/response link between the arbiter and the byte-level I2C master.
//   m_enable, m_rw, m_addr, m_wdata : command toward the I2C master
//   m_ready, m_rdata                : status and read byte from the I2C master
// modport master : the arbiter side (drives the command)
// modport slave  : the I2C master side (drives ready and read data)
interface i2c_bus_arbiter_if;
    import i2c_arb_pkg::*;

    logic              m_enable;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_enable, m_rw, m_addr, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_enable, m_rw, m_addr, m_wdata,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo N.
//   req    : request vector
//   ptr    : search start index
//   onehot : one-hot of the selected request (all zero when none)
//   idx    : binary index of the selected request
//   any    : at least one request is pending
module i2c_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                             = 1'b1;
                idx                             = IW'((int'(ptr) + k) % N);
                onehot[(int'(ptr) + k) % N]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master among N_REQ clients.
//   clk, rst_n                         : system clock, async active-low reset
//   req, req_rw, req_addr, req_wdata   : per-client request level and command
//   gnt                                : one-hot, high while a client owns the master
//   done, err                          : one-cycle completion pulse, timeout flag
//   rdata                              : last read byte, held until next completion
//   bus                                : command/status link to the I2C master
//
// state  | meaning
// IDLE   | waiting for a request while the master reports ready
// ISSUE  | m_enable held until the master drops ready (accept)
// BUSY   | transfer in flight, waiting for ready to return
// FINISH | one-cycle done/err pulse, pointer advances
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ACCEPT_TIMEOUT = 1024,
    parameter int XFER_TIMEOUT   = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_rw,
    input  logic [ADDR_W*N_REQ-1:0]  req_addr,
    input  logic [DATA_W*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    i2c_bus_arbiter_if.master        bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = timer_width(ACCEPT_TIMEOUT, XFER_TIMEOUT);

    arb_state_t        state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic              err_flag, err_nxt;
    logic              latch, capture;
    logic              ready_meta, ready_s;
    logic [IW-1:0]     ptr, idx;
    logic [N_REQ-1:0]  owner;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    i2c_rr_pick #(.N(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        err_nxt   = err_flag;
        latch     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && ready_s) begin
                    state_nxt = ISSUE;
                    latch     = 1'b1;
                    timer_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            ISSUE: begin
                if (!ready_s) begin
                    state_nxt = BUSY;
                    timer_nxt = '0;
                end else if (timer == TW'(ACCEPT_TIMEOUT - 1)) begin
                    state_nxt = FINISH;
                    err_nxt   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            BUSY: begin
                if (ready_s) begin
                    state_nxt = FINISH;
                    capture   = cmd_rw;
                    timer_nxt = '0;
                end else if (timer == TW'(XFER_TIMEOUT - 1)) begin
                    state_nxt = FINISH;
                    err_nxt   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_meta <= 1'b0;
            ready_s    <= 1'b0;
            state      <= IDLE;
            timer      <= '0;
            err_flag   <= 1'b0;
            ptr        <= '0;
            idx        <= '0;
            owner      <= '0;
            cmd_rw     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata      <= '0;
        end else begin
            ready_meta <= bus.m_ready;
            ready_s    <= ready_meta;
            state      <= state_nxt;
            timer      <= timer_nxt;
            err_flag   <= err_nxt;
            if (latch) begin
                idx       <= pick_idx;
                owner     <= pick_onehot;
                cmd_rw    <= req_rw[pick_idx];
                cmd_addr  <= req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
                cmd_wdata <= req_wdata[DATA_W*int'(pick_idx) +: DATA_W];
            end
            if (capture) begin
                rdata <= bus.m_rdata;
            end
            // Moving past the served client keeps it from being re-picked
            // ahead of anyone else still waiting.
            if (state == FINISH) begin
                ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
            end
        end
    end

    // Handshake outputs are decodes of the async-reset state register, so
    // they drop the moment rst_n asserts.
    assign gnt  = (state == ISSUE || state == BUSY) ? owner : '0;
    assign done = (state == FINISH) ? owner : '0;
    assign err  = (state == FINISH) && err_flag;

    assign bus.m_enable = (state == ISSUE);
    assign bus.m_rw     = cmd_rw;
    assign bus.m_addr   = cmd_addr;
    assign bus.m_wdata  = cmd_wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a behavioural I2C master model and
// a completion scoreboard (done vector, err, rdata).
module tb_i2c_bus_arbiter;
    localparam int N   = 4;
    localparam int ACC = 16;
    localparam int XFR = 600;

    typedef struct packed {
        logic [3:0] d;
        logic       e;
        logic [7:0] r;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done;
    logic        err;
    logic [7:0]  rdata;

    i2c_bus_arbiter_if bus ();

    i2c_bus_arbiter #(.N_REQ(N), .ACCEPT_TIMEOUT(ACC), .XFER_TIMEOUT(XFR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // master model controls
    int       acc_dly  = 3;
    int       busy_len = 20;
    bit       hang_accept = 1'b0;
    bit       hang_busy   = 1'b0;
    logic [7:0] rd_byte   = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_done(input logic [3:0] d, input logic e, input logic [7:0] r);
        exp_t x;
        x.d = d;
        x.e = e;
        x.r = r;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done != 4'b0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_gnt(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (gnt != 4'b0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Behavioural byte master: drops ready acc_dly cycles after seeing
    // enable, raises it busy_len cycles later with rd_byte.
    initial begin
        int phase = 0;
        int cnt   = 0;
        bus.m_ready = 1'b1;
        bus.m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            case (phase)
                0: if (bus.m_enable && !hang_accept) begin
                    cnt   = 1;
                    phase = 1;
                end
                1: if (cnt >= acc_dly) begin
                    bus.m_ready = 1'b0;
                    cnt   = 0;
                    phase = 2;
                end else begin
                    cnt++;
                end
                default: begin
                    cnt++;
                    if (!hang_busy && cnt >= busy_len) begin
                        bus.m_ready = 1'b1;
                        bus.m_rdata = rd_byte;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Completion monitor / scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
                if (done == 4'b0) begin
                    check("err_without_done", 32'(err), 32'd0);
                end else if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    x = sb.pop_front();
                    check("done_vec", 32'(done), 32'(x.d));
                    check("done_err", 32'(err), 32'(x.e));
                    check("done_rdata", 32'(rdata), 32'(x.r));
                end
            end
        end
    end

    initial begin
        int en_cnt;
        int busy_cnt;
        int g_cnt;
        bit seen;

        rst_n     = 1'b0;
        req       = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_m_enable", 32'(bus.m_enable), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_m_addr", 32'(bus.m_addr), 32'd0);
        check("rst_m_wdata", 32'(bus.m_wdata), 32'd0);
        check("rst_m_rw", 32'(bus.m_rw), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_quiet", 32'({gnt, done, err, bus.m_enable}), 32'd0);

        // Contention: clients 0,1,3 at once; client 0 re-requests -> 0,1,3,0
        rd_byte  = 8'h5A;
        busy_len = 20;
        req_rw   = 4'b0010;
        req_addr = {7'h33, 7'h22, 7'h11, 7'h10};
        req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        expect_done(4'b0001, 1'b0, 8'h00);
        expect_done(4'b0010, 1'b0, 8'h5A);
        expect_done(4'b1000, 1'b0, 8'h5A);
        expect_done(4'b0001, 1'b0, 8'h5A);
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_done(200, "contention_timeout");
            if (k > 0) req = req & ~done;
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Single read: client 0, addr 0x1D, master answers 0xA5 after 500
        rd_byte  = 8'hA5;
        busy_len = 500;
        req_rw[0] = 1'b1;
        req_addr[6:0] = 7'h1D;
        expect_done(4'b0001, 1'b0, 8'hA5);
        req[0] = 1'b1;
        wait_gnt(20, "read_gnt_timeout");
        repeat (100) @(negedge clk);
        check("read_m_addr", 32'(bus.m_addr), 32'h1D);
        check("read_m_rw", 32'(bus.m_rw), 32'd1);
        check("read_gnt", 32'(gnt), 32'b0001);
        wait_done(1000, "read_done_timeout");
        check("read_m_addr_end", 32'(bus.m_addr), 32'h1D);
        req[0] = 1'b0;
        busy_len = 20;
        repeat (3) @(negedge clk);

        // Write: client 2 writes 0x3C to 0x1D; later edits to req_* ignored
        req_rw[2] = 1'b0;
        req_addr[20:14] = 7'h1D;
        req_wdata[23:16] = 8'h3C;
        expect_done(4'b0100, 1'b0, 8'hA5);
        req[2] = 1'b1;
        wait_gnt(20, "write_gnt_timeout");
        req_wdata[23:16] = 8'hFF;
        req_addr[20:14]  = 7'h7F;
        req_rw[2] = 1'b1;
        repeat (8) @(negedge clk);
        check("write_gnt", 32'(gnt), 32'b0100);
        check("write_m_rw", 32'(bus.m_rw), 32'd0);
        check("write_m_wdata", 32'(bus.m_wdata), 32'h3C);
        check("write_m_addr", 32'(bus.m_addr), 32'h1D);
        wait_done(200, "write_done_timeout");
        req[2] = 1'b0;
        repeat (3) @(negedge clk);

        // Accept timeout: ready stuck high; pointer is at 3 so 3 goes first
        hang_accept = 1'b1;
        expect_done(4'b1000, 1'b1, 8'hA5);
        expect_done(4'b0010, 1'b1, 8'hA5);
        req = 4'b1010;
        en_cnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_enable) en_cnt++;
            if (done != 4'b0) seen = 1'b1;
        end
        check("acc_done_timeout", 32'(seen), 32'd1);
        check("acc_enable_cycles", 32'(en_cnt), 32'(ACC));
        req[3] = 1'b0;
        repeat (2) @(negedge clk);
        check("acc_next_gnt", 32'(gnt), 32'b0010);
        wait_done(200, "acc_done2_timeout");
        req[1] = 1'b0;
        hang_accept = 1'b0;
        repeat (3) @(negedge clk);

        // Transfer timeout: ready falls and never returns
        hang_busy = 1'b1;
        req_rw[0] = 1'b1;
        expect_done(4'b0001, 1'b1, 8'hA5);
        req[0] = 1'b1;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 4'b0 && !bus.m_enable) busy_cnt++;
            if (done != 4'b0) seen = 1'b1;
        end
        check("xfer_done_timeout", 32'(seen), 32'd1);
        check("xfer_busy_cycles", 32'(busy_cnt), 32'(XFR));
        g_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != 4'b0) g_cnt++;
        end
        check("xfer_no_gnt_while_busy", 32'(g_cnt), 32'd0);
        rd_byte = 8'hC3;
        expect_done(4'b0001, 1'b0, 8'hC3);
        hang_busy = 1'b0;
        wait_done(200, "xfer_retry_timeout");
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-BUSY
        hang_busy = 1'b1;
        req_rw[1] = 1'b1;
        req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 4'b0 && !bus.m_enable) seen = 1'b1;
        end
        check("rst_busy_reach", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_gnt", 32'(gnt), 32'd0);
        check("rst_async_enable", 32'(bus.m_enable), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdata_cleared", 32'(rdata), 32'd0);
        g_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt != 4'b0) g_cnt++;
        end
        check("rst_no_gnt_until_ready", 32'(g_cnt), 32'd0);
        rd_byte = 8'h96;
        expect_done(4'b0010, 1'b0, 8'h96);
        hang_busy = 1'b0;
        wait_done(200, "rst_retry_timeout");
        req[1] = 1'b0;
        repeat (5) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
